// File: rtl/fetch_seq_pkg.sv
// Shared types for the instruction-cycle sequencer and its program-counter integration.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        EXEC   = 3'd3,
        UPDATE = 3'd4,
        HALT   = 3'd5
    } seq_state_e;

    localparam logic PC_SEL_SEQ    = 1'b0;
    localparam logic PC_SEL_BRANCH = 1'b1;

endpackage

// File: rtl/fetch_ack_timer.sv
// Loadable down-counter bounding how long FETCH may wait for a memory ack.
module fetch_ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Load on FETCH entry, then count down once per waiting cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - ONE_VAL;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of one means the current FETCH cycle is the last one allowed.
    assign expired = enable && (cnt_q == ONE_VAL);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-cycle controller: fetch, issue, execute-wait and PC update around a 12-bit PC.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Run,
    input  logic               Halt_Req,
    input  logic [ADDR_W-1:0]  PC_in,
    output logic               Imem_Req,
    output logic [ADDR_W-1:0]  Imem_Addr,
    input  logic               Imem_Ack,
    input  logic [INSTR_W-1:0] Imem_Data,
    output logic [INSTR_W-1:0] Instr_out,
    output logic               Instr_Valid,
    input  logic               Dec_Ready,
    input  logic               Exec_Done,
    input  logic               Branch_Taken,
    input  logic [ADDR_W-1:0]  Branch_Target_in,
    output logic               PC_Enable,
    output logic               PC_Next_Sel,
    output logic [ADDR_W-1:0]  BranchTarget_out,
    output logic               Halted,
    output logic               Timeout_Err,
    output logic [15:0]        Instr_Count
);

    seq_state_e         state_d, state_q;
    logic               imem_req_d, imem_req_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic               instr_valid_d, instr_valid_q;
    logic               pc_enable_d, pc_enable_q;
    logic               pc_next_sel_d, pc_next_sel_q;
    logic [ADDR_W-1:0]  br_target_d, br_target_q;
    logic               halted_d, halted_q;
    logic               timeout_err_d, timeout_err_q;
    logic [15:0]        instr_count_d, instr_count_q;
    logic               timer_load_s, timer_clear_s, timer_enable_s, timer_expired_s;

    fetch_ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk    (Clk),
        .rst    (Reset),
        .clear  (timer_clear_s),
        .load   (timer_load_s),
        .enable (timer_enable_s),
        .expired(timer_expired_s)
    );

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        pc_next_sel_d = pc_next_sel_q;
        br_target_d   = br_target_q;
        timeout_err_d = timeout_err_q;
        instr_count_d = instr_count_q;
        case (state_q)
            IDLE: begin
                if (Halt_Req) begin
                    state_d = HALT;
                end else if (Run) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (Imem_Ack) begin
                    instr_d = Imem_Data;
                    state_d = ISSUE;
                end else if (timer_expired_s) begin
                    timeout_err_d = 1'b1;
                    state_d       = HALT;
                end else begin
                    state_d = FETCH;
                end
            end
            ISSUE: begin
                if (Dec_Ready) begin
                    state_d = EXEC;
                end else begin
                    state_d = ISSUE;
                end
            end
            EXEC: begin
                if (Exec_Done) begin
                    pc_next_sel_d = Branch_Taken ? PC_SEL_BRANCH : PC_SEL_SEQ;
                    br_target_d   = Branch_Target_in;
                    instr_count_d = instr_count_q + 16'd1;
                    state_d       = UPDATE;
                end else begin
                    state_d = EXEC;
                end
            end
            UPDATE: begin
                pc_next_sel_d = PC_SEL_SEQ;
                if (Halt_Req || !Run) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH;
                end
            end
            HALT: begin
                if (Run && !Halt_Req && !timeout_err_q) begin
                    state_d = FETCH;
                end else begin
                    state_d = HALT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        imem_req_d    = (state_d == FETCH);
        instr_valid_d = (state_d == ISSUE);
        pc_enable_d   = (state_d == UPDATE);
        halted_d      = (state_d == HALT);
    end

    // The timer is armed on every entry into FETCH and idles elsewhere.
    always_comb begin
        timer_load_s   = (state_d == FETCH) && (state_q != FETCH);
        timer_enable_s = (state_q == FETCH);
        timer_clear_s  = (state_q != FETCH) && !timer_load_s;
    end

    // State and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            instr_q       <= {INSTR_W{1'b0}};
            instr_valid_q <= 1'b0;
            pc_enable_q   <= 1'b0;
            pc_next_sel_q <= PC_SEL_SEQ;
            br_target_q   <= {ADDR_W{1'b0}};
            halted_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_enable_q   <= pc_enable_d;
            pc_next_sel_q <= pc_next_sel_d;
            br_target_q   <= br_target_d;
            halted_q      <= halted_d;
            timeout_err_q <= timeout_err_d;
            instr_count_q <= instr_count_d;
        end
    end

    // The PC updates on the same edge FETCH is entered, so the address tracks PC_in directly.
    assign Imem_Addr        = imem_req_q ? PC_in : {ADDR_W{1'b0}};
    assign Imem_Req         = imem_req_q;
    assign Instr_out        = instr_q;
    assign Instr_Valid      = instr_valid_q;
    assign PC_Enable        = pc_enable_q;
    assign PC_Next_Sel      = pc_next_sel_q;
    assign BranchTarget_out = br_target_q;
    assign Halted           = halted_q;
    assign Timeout_Err      = timeout_err_q;
    assign Instr_Count      = instr_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized instruction cycles against a transaction-level expectation of the sequencer.
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Run;
    logic        Halt_Req;
    logic [11:0] PC_in;
    logic        Imem_Req;
    logic [11:0] Imem_Addr;
    logic        Imem_Ack;
    logic [15:0] Imem_Data;
    logic [15:0] Instr_out;
    logic        Instr_Valid;
    logic        Dec_Ready;
    logic        Exec_Done;
    logic        Branch_Taken;
    logic [11:0] Branch_Target_in;
    logic        PC_Enable;
    logic        PC_Next_Sel;
    logic [11:0] BranchTarget_out;
    logic        Halted;
    logic        Timeout_Err;
    logic [15:0] Instr_Count;

    int          vectors = 0;
    int          miscompares = 0;
    logic [11:0] pc_exp;
    logic [11:0] last_tgt;
    logic [15:0] cnt_exp;

    fetch_sequencer #(.ADDR_W(12), .INSTR_W(16), .ACK_TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Halt_Req(Halt_Req), .PC_in(PC_in),
        .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data),
        .Instr_out(Instr_out), .Instr_Valid(Instr_Valid), .Dec_Ready(Dec_Ready),
        .Exec_Done(Exec_Done), .Branch_Taken(Branch_Taken), .Branch_Target_in(Branch_Target_in),
        .PC_Enable(PC_Enable), .PC_Next_Sel(PC_Next_Sel), .BranchTarget_out(BranchTarget_out),
        .Halted(Halted), .Timeout_Err(Timeout_Err), .Instr_Count(Instr_Count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the bench plays the program counter, which follows the strobe it saw.
    task automatic tick();
        logic        en;
        logic        sel;
        logic [11:0] tgt;
        en  = PC_Enable;
        sel = PC_Next_Sel;
        tgt = BranchTarget_out;
        @(posedge Clk);
        if (en === 1'b1) PC_in = sel ? tgt : PC_in + 12'd1;
        @(negedge Clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_req"},    32'(Imem_Req), 32'd0);
        check({tag, "_addr"},   32'(Imem_Addr), 32'd0);
        check({tag, "_instr"},  32'(Instr_out), 32'd0);
        check({tag, "_valid"},  32'(Instr_Valid), 32'd0);
        check({tag, "_pcen"},   32'(PC_Enable), 32'd0);
        check({tag, "_sel"},    32'(PC_Next_Sel), 32'd0);
        check({tag, "_tgt"},    32'(BranchTarget_out), 32'd0);
        check({tag, "_halted"}, 32'(Halted), 32'd0);
        check({tag, "_terr"},   32'(Timeout_Err), 32'd0);
        check({tag, "_count"},  32'(Instr_Count), 32'd0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset(input string tag);
        #2 Reset = 1'b1;
        #1 check_cleared(tag);
        Run = 1'b0;
        Halt_Req = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        PC_in = 12'd0;
        pc_exp = 12'd0;
        last_tgt = 12'd0;
        cnt_exp = 16'd0;
    endtask

    // One full instruction starting in its first FETCH cycle.
    // stop: 0 continue, 1 Halt_Req at boundary, 2 Run low at boundary.
    task automatic run_instr(input int ack_wait, input int rdy_wait, input int exec_wait,
                             input logic br, input logic [11:0] tgt, input logic [15:0] data,
                             input int stop);
        for (int k = 0; k <= ack_wait; k++) begin
            check("fetch_req", 32'(Imem_Req), 32'd1);
            check("fetch_addr", 32'(Imem_Addr), 32'(pc_exp));
            check("fetch_valid", 32'(Instr_Valid), 32'd0);
            if (k == 0) begin
                check("sel_back_seq", 32'(PC_Next_Sel), 32'd0);
                check("tgt_hold", 32'(BranchTarget_out), 32'(last_tgt));
            end
            Imem_Ack     = (k == ack_wait);
            Imem_Data    = (k == ack_wait) ? data : 16'($urandom);
            Exec_Done    = 1'($urandom);
            Branch_Taken = 1'($urandom);
            Halt_Req     = 1'($urandom);
            Run          = 1'($urandom);
            tick();
        end
        Imem_Ack = 1'b0;
        for (int k = 0; k <= rdy_wait; k++) begin
            check("issue_valid", 32'(Instr_Valid), 32'd1);
            check("issue_instr", 32'(Instr_out), 32'(data));
            check("issue_req", 32'(Imem_Req), 32'd0);
            check("issue_pcen", 32'(PC_Enable), 32'd0);
            Dec_Ready = (k == rdy_wait);
            Exec_Done = 1'($urandom);
            tick();
        end
        Dec_Ready = 1'b0;
        Run       = (stop != 2);
        Halt_Req  = (stop == 1);
        for (int k = 0; k <= exec_wait; k++) begin
            check("exec_valid", 32'(Instr_Valid), 32'd0);
            check("exec_pcen", 32'(PC_Enable), 32'd0);
            check("exec_req", 32'(Imem_Req), 32'd0);
            Exec_Done        = (k == exec_wait);
            Branch_Taken     = (k == exec_wait) ? br : 1'($urandom);
            Branch_Target_in = (k == exec_wait) ? tgt : 12'($urandom);
            tick();
        end
        Exec_Done = 1'b0;
        cnt_exp   = cnt_exp + 16'd1;
        check("upd_pcen", 32'(PC_Enable), 32'd1);
        check("upd_sel", 32'(PC_Next_Sel), 32'(br));
        check("upd_tgt", 32'(BranchTarget_out), 32'(tgt));
        check("upd_count", 32'(Instr_Count), 32'(cnt_exp));
        check("upd_terr", 32'(Timeout_Err), 32'd0);
        pc_exp   = br ? tgt : pc_exp + 12'd1;
        last_tgt = tgt;
        tick();
        check("post_pcen", 32'(PC_Enable), 32'd0);
        check("post_halted", 32'(Halted), (stop != 0) ? 32'd1 : 32'd0);
        if (stop != 0) check("post_req", 32'(Imem_Req), 32'd0);
    endtask

    initial begin
        int ack_w;
        Reset = 1'b1; Run = 1'b0; Halt_Req = 1'b0; PC_in = 12'd0;
        Imem_Ack = 1'b0; Imem_Data = 16'd0; Dec_Ready = 1'b0; Exec_Done = 1'b0;
        Branch_Taken = 1'b0; Branch_Target_in = 12'd0;
        pc_exp = 12'd0; last_tgt = 12'd0; cnt_exp = 16'd0;
        @(negedge Clk);
        @(negedge Clk);
        check_cleared("reset");
        Reset = 1'b0;

        // IDLE holds without Run.
        tick();
        check("idle_req", 32'(Imem_Req), 32'd0);
        check("idle_halted", 32'(Halted), 32'd0);

        // Basic sequential instruction, then a taken branch, then backpressure.
        Run = 1'b1;
        tick();
        run_instr(1, 0, 2, 1'b0, 12'h123, 16'hA5A5, 0);
        run_instr(0, 0, 1, 1'b1, 12'h3F0, 16'h1234, 0);
        run_instr(0, 5, 0, 1'b0, 12'h055, 16'hBEEF, 0);
        // Ack on the last allowed cycle wins over the timeout.
        run_instr(14, 1, 0, 1'b0, 12'h7FF, 16'h0F0F, 0);

        // Halt at the boundary, then resume at the updated PC.
        run_instr(0, 0, 3, 1'b1, 12'hABC, 16'h5555, 1);
        for (int k = 0; k < 3; k++) begin
            Run = 1'($urandom);
            tick();
            check("halt_hold", 32'(Halted), 32'd1);
        end
        Halt_Req = 1'b0; Run = 1'b1;
        tick();
        run_instr(2, 2, 0, 1'b0, 12'h001, 16'hC3C3, 0);

        // Timeout after 15 unanswered FETCH cycles; sticky until reset.
        Imem_Ack = 1'b0;
        for (int k = 0; k < 15; k++) begin
            check("to_req", 32'(Imem_Req), 32'd1);
            check("to_terr_low", 32'(Timeout_Err), 32'd0);
            tick();
        end
        check("to_terr", 32'(Timeout_Err), 32'd1);
        check("to_halted", 32'(Halted), 32'd1);
        check("to_req_off", 32'(Imem_Req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            Run = k[0]; Halt_Req = 1'b0;
            tick();
            check("to_stuck", 32'(Halted), 32'd1);
            check("to_sticky", 32'(Timeout_Err), 32'd1);
        end
        do_reset("to_reset");

        // IDLE with Halt_Req goes to HALT, and leaves once released.
        Run = 1'b1; Halt_Req = 1'b1;
        tick();
        check("idle_to_halt", 32'(Halted), 32'd1);
        Halt_Req = 1'b0;
        tick();
        check("halt_to_fetch", 32'(Halted), 32'd0);

        // Randomized instruction stream with occasional boundary stops.
        for (int n = 0; n < 40; n++) begin
            int stop;
            stop  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            ack_w = int'($urandom_range(0, 14));
            run_instr(ack_w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), 12'($urandom), 16'($urandom), stop);
            if (stop != 0) begin
                Halt_Req = 1'b1;
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                    Run = 1'($urandom);
                    tick();
                    check("rnd_halt_hold", 32'(Halted), 32'd1);
                end
                Halt_Req = 1'b0; Run = 1'b1;
                tick();
            end
        end

        // Reset mid-FETCH drops the request and the retired count.
        check("pre_reset_req", 32'(Imem_Req), 32'd1);
        do_reset("mid_reset");
        tick();
        check("mid_reset_idle", 32'(Imem_Req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
